// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 priority encoder: captures a request vector and hands out
// one set-bit index per valid/ready handshake, clearing each bit as it is served.
module enc8to3_seq #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [0:7] d,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] code,
  output logic [3:0] remain,
  output logic       busy,
  output logic       zero,
  output logic       done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t     r_state;
  logic [0:7] r_pend;
  logic       r_zero;
  logic       r_done;

  logic [2:0] w_idx;
  logic [3:0] w_cnt;
  logic [0:7] w_pend_next;
  logic       w_serve;

  // Scan so the highest-priority set bit is the last one written.
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      logic [2:0] k;
      k = LOW_FIRST ? 3'(7 - i) : 3'(i);
      if (r_pend[k]) w_idx = k;
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_cnt = w_cnt + {3'b000, r_pend[i]};
    end
  end

  always_comb begin
    w_pend_next        = r_pend;
    w_pend_next[w_idx] = 1'b0;
  end

  assign w_serve = (r_state == SERVE);

  // All handshake outputs derive from registered state/pend only.
  assign valid  = w_serve;
  assign busy   = w_serve;
  assign code   = w_serve ? w_idx : 3'd0;
  assign remain = w_cnt;
  assign zero   = r_zero;
  assign done   = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_zero <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            if (d != '0) begin
              r_pend  <= d;
              r_state <= SERVE;
            end else begin
              r_zero <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (ready) begin
            r_pend <= w_pend_next;
            if (w_pend_next == '0) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_pend  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc8to3_seq.sv
// Directed bench for enc8to3_seq: one instance per priority direction, sharing inputs.
module tb_enc8to3_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [0:7] d = '0;
  logic       ready = 1'b0;

  logic       lo_valid, lo_busy, lo_zero, lo_done;
  logic [2:0] lo_code;
  logic [3:0] lo_remain;
  logic       hi_valid, hi_busy, hi_zero, hi_done;
  logic [2:0] hi_code;
  logic [3:0] hi_remain;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enc8to3_seq #(.LOW_FIRST(1'b1)) u_lo (
    .clk(clk), .rst(rst), .load(load), .d(d), .ready(ready),
    .valid(lo_valid), .code(lo_code), .remain(lo_remain),
    .busy(lo_busy), .zero(lo_zero), .done(lo_done)
  );

  enc8to3_seq #(.LOW_FIRST(1'b0)) u_hi (
    .clk(clk), .rst(rst), .load(load), .d(d), .ready(ready),
    .valid(hi_valid), .code(hi_code), .remain(hi_remain),
    .busy(hi_busy), .zero(hi_zero), .done(hi_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] exp_zero;
    exp_zero = '0;
    #2;
    checks++;
    if ({lo_valid, lo_code, lo_remain, lo_busy, lo_zero, lo_done} !== exp_zero) begin
      errors++;
      $display("FAIL reset_init: got %b expected %b",
               {lo_valid, lo_code, lo_remain, lo_busy, lo_zero, lo_done}, exp_zero);
    end
    step();
    rst = 1'b0;
    step();
    load = 1'b1; d = 8'b1011_0000; ready = 1'b0;
    step();
    load = 1'b0;
    checks++;
    if (lo_code !== 3'd0 || lo_remain !== 4'd3 || lo_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: code=%0d remain=%0d valid=%b expected 0 3 1",
               lo_code, lo_remain, lo_valid);
    end
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({lo_valid, lo_code, lo_remain, lo_busy, lo_zero, lo_done} !== exp_zero) begin
      errors++;
      $display("FAIL reset_midserve: got %b expected %b",
               {lo_valid, lo_code, lo_remain, lo_busy, lo_zero, lo_done}, exp_zero);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (lo_valid !== 1'b0 || lo_busy !== 1'b0 || lo_remain !== 4'd0) begin
        errors++;
        $display("FAIL reset_idle_hold: valid=%b busy=%b remain=%0d expected 0 0 0",
                 lo_valid, lo_busy, lo_remain);
      end
    end
  endtask

  task automatic test_low_first();
    logic [2:0] exp_code [3];
    logic [3:0] exp_rem [3];
    exp_code = '{3'd1, 3'd4, 3'd7};
    exp_rem  = '{4'd3, 4'd2, 4'd1};
    load = 1'b1; d = 8'b0100_1001; ready = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lo_valid !== 1'b1 || lo_code !== exp_code[i] || lo_remain !== exp_rem[i]) begin
        errors++;
        $display("FAIL low_first[%0d]: valid=%b code=%0d remain=%0d expected 1 %0d %0d",
                 i, lo_valid, lo_code, lo_remain, exp_code[i], exp_rem[i]);
      end
      step();
    end
    checks++;
    if (lo_done !== 1'b1 || lo_valid !== 1'b0 || lo_code !== 3'd0) begin
      errors++;
      $display("FAIL low_first_done: done=%b valid=%b code=%0d expected 1 0 0",
               lo_done, lo_valid, lo_code);
    end
    step();
    checks++;
    if (lo_done !== 1'b0) begin
      errors++;
      $display("FAIL low_first_done_width: done=%b expected 0", lo_done);
    end
  endtask

  task automatic test_high_first();
    logic [2:0] exp_code [3];
    logic [3:0] exp_rem [3];
    exp_code = '{3'd7, 3'd4, 3'd1};
    exp_rem  = '{4'd3, 4'd2, 4'd1};
    load = 1'b1; d = 8'b0100_1001; ready = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hi_valid !== 1'b1 || hi_code !== exp_code[i] || hi_remain !== exp_rem[i]) begin
        errors++;
        $display("FAIL high_first[%0d]: valid=%b code=%0d remain=%0d expected 1 %0d %0d",
                 i, hi_valid, hi_code, hi_remain, exp_code[i], exp_rem[i]);
      end
      step();
    end
    checks++;
    if (hi_done !== 1'b1 || hi_valid !== 1'b0) begin
      errors++;
      $display("FAIL high_first_done: done=%b valid=%b expected 1 0", hi_done, hi_valid);
    end
    step();
  endtask

  task automatic test_backpressure();
    load = 1'b1; d = 8'b1000_0001; ready = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (lo_valid !== 1'b1 || lo_code !== 3'd0 || lo_remain !== 4'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b code=%0d remain=%0d expected 1 0 2",
                 i, lo_valid, lo_code, lo_remain);
      end
      step();
    end
    ready = 1'b1;
    step();
    checks++;
    if (lo_valid !== 1'b1 || lo_code !== 3'd7 || lo_remain !== 4'd1) begin
      errors++;
      $display("FAIL bp_release: valid=%b code=%0d remain=%0d expected 1 7 1",
               lo_valid, lo_code, lo_remain);
    end
    step();
    checks++;
    if (lo_done !== 1'b1 || lo_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: done=%b valid=%b expected 1 0", lo_done, lo_valid);
    end
    ready = 1'b0;
    step();
  endtask

  task automatic test_zero_and_ignore();
    logic [3:0] exp_rem [2];
    exp_rem = '{4'd2, 4'd1};
    load = 1'b1; d = 8'b0000_0000;
    step();
    load = 1'b0;
    checks++;
    if (lo_zero !== 1'b1 || lo_busy !== 1'b0 || lo_valid !== 1'b0 || lo_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: zero=%b busy=%b valid=%b done=%b expected 1 0 0 0",
               lo_zero, lo_busy, lo_valid, lo_done);
    end
    step();
    checks++;
    if (lo_zero !== 1'b0 || lo_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_width: zero=%b busy=%b expected 0 0", lo_zero, lo_busy);
    end
    load = 1'b1; d = 8'b0000_0011;
    step();
    d = 8'b1111_1111; ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lo_remain !== exp_rem[i] || lo_code !== 3'(6 + i)) begin
        errors++;
        $display("FAIL ignore_load[%0d]: remain=%0d code=%0d expected %0d %0d",
                 i, lo_remain, lo_code, exp_rem[i], 6 + i);
      end
      step();
    end
    load = 1'b0; d = '0;
    checks++;
    if (lo_done !== 1'b1 || lo_remain !== 4'd0 || lo_zero !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done: done=%b remain=%0d zero=%b expected 1 0 0",
               lo_done, lo_remain, lo_zero);
    end
    ready = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [0:7] v;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = '0;
      v[i] = 1'b1;
      load = 1'b1; d = v;
      step();
      load = 1'b0;
      checks++;
      if (lo_valid !== 1'b1 || lo_code !== 3'(i) || lo_remain !== 4'd1 ||
          hi_code !== 3'(i)) begin
        errors++;
        $display("FAIL onehot_code[%0d]: valid=%b code=%0d hi_code=%0d remain=%0d expected 1 %0d %0d 1",
                 i, lo_valid, lo_code, hi_code, lo_remain, i, i);
      end
      step();
      checks++;
      if (lo_done !== 1'b1 || lo_valid !== 1'b0 || hi_done !== 1'b1) begin
        errors++;
        $display("FAIL onehot_done[%0d]: done=%b valid=%b hi_done=%b expected 1 0 1",
                 i, lo_done, lo_valid, hi_done);
      end
    end
    ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_low_first();
    test_high_first();
    test_backpressure();
    test_zero_and_ignore();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
